// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port program/data memory between the CPU and the host loader.
// Define ARB_RR_EN for round-robin tie-breaking; the default build gives the CPU fixed priority.
module mem_port_arbiter #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_gnt,
  output logic          ldr_rvalid,
  output logic [DW-1:0] ldr_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUS_CPU = 2'd1,
    BUS_LDR = 2'd2,
    RD_WAIT = 2'd3
  } state_t;

  state_t        state_reg;
  logic          sel_reg;       // port of the access in flight: 0 = CPU, 1 = loader
  logic          we_reg;
  logic [1:0]    gnt_reg;
  logic [1:0]    rvalid_reg;
  logic [DW-1:0] rdata_reg [2];
  logic          mem_rd_reg;
  logic          mem_wr_reg;
  logic [AW-1:0] mem_addr_reg;
  logic [DW-1:0] mem_wdata_reg;
`ifdef ARB_RR_EN
  logic          rr_ptr_reg;    // last-granted port
`endif

  logic          any_req;
  logic          win_ldr;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  always_comb begin
    any_req = cpu_req | ldr_req;
`ifdef ARB_RR_EN
    win_ldr = ldr_req & (~cpu_req | ~rr_ptr_reg);
`else
    win_ldr = ldr_req & ~cpu_req;
`endif
    win_we    = win_ldr ? ldr_we    : cpu_we;
    win_addr  = win_ldr ? ldr_addr  : cpu_addr;
    win_wdata = win_ldr ? ldr_wdata : cpu_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_reg     <= IDLE;
      sel_reg       <= 1'b0;
      we_reg        <= 1'b0;
      gnt_reg       <= 2'b00;
      rvalid_reg    <= 2'b00;
      rdata_reg[0]  <= '0;
      rdata_reg[1]  <= '0;
      mem_rd_reg    <= 1'b0;
      mem_wr_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
`ifdef ARB_RR_EN
      rr_ptr_reg    <= 1'b0;
`endif
    end else begin
      gnt_reg    <= 2'b00;
      rvalid_reg <= 2'b00;
      mem_rd_reg <= 1'b0;
      mem_wr_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            sel_reg          <= win_ldr;
            we_reg           <= win_we;
            mem_addr_reg     <= win_addr;
            mem_wdata_reg    <= win_wdata;
            mem_rd_reg       <= ~win_we;
            mem_wr_reg       <= win_we;
            gnt_reg[win_ldr] <= 1'b1;
            state_reg        <= win_ldr ? BUS_LDR : BUS_CPU;
`ifdef ARB_RR_EN
            rr_ptr_reg       <= win_ldr;
`endif
          end
        end
        BUS_CPU, BUS_LDR: begin
          if (we_reg) begin
            state_reg <= IDLE;
          end else begin
            rvalid_reg[sel_reg] <= 1'b1;
            state_reg           <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          rdata_reg[sel_reg] <= mem_rdata;
          state_reg          <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [1:0]    rvalid_out;
  logic [DW-1:0] rdata_out [2];

  // Read data passes straight through while its rvalid is up, then is held.
  // rvalid is masked by reset so an aborted read never reports completion.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign rvalid_out[gi] = rvalid_reg[gi] & ~rst_;
      assign rdata_out[gi]  = (state_reg == RD_WAIT && sel_reg == 1'(gi)) ? mem_rdata
                                                                          : rdata_reg[gi];
    end
  endgenerate

  assign cpu_gnt    = gnt_reg[0];
  assign ldr_gnt    = gnt_reg[1];
  assign cpu_rvalid = rvalid_out[0];
  assign ldr_rvalid = rvalid_out[1];
  assign cpu_rdata  = rdata_out[0];
  assign ldr_rdata  = rdata_out[1];
  assign mem_rd     = mem_rd_reg;
  assign mem_wr     = mem_wr_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a registered-read memory behind it.
// Expected tie-break order follows ARB_RR_EN when the bench is built with it.
module tb_mem_port_arbiter;
  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_;
  logic          cpu_req, cpu_we, ldr_req, ldr_we;
  logic [AW-1:0] cpu_addr, ldr_addr;
  logic [DW-1:0] cpu_wdata, ldr_wdata;
  logic          cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid;
  logic [DW-1:0] cpu_rdata, ldr_rdata;
  logic          mem_rd, mem_wr, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [32];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Single-port memory: write at the edge, read data valid the cycle after mem_rd.
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_(rst_),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic       exp_ldr [4];
    logic       excl_bad;
    int         g;
    int         last_cyc;
    logic [7:0] wa [3];
    logic [7:0] wd [3];

`ifdef ARB_RR_EN
    exp_ldr[0] = 1'b1; exp_ldr[1] = 1'b0; exp_ldr[2] = 1'b1; exp_ldr[3] = 1'b0;
`else
    exp_ldr[0] = 1'b0; exp_ldr[1] = 1'b0; exp_ldr[2] = 1'b0; exp_ldr[3] = 1'b0;
`endif

    // Reset held two cycles with both requests up (both write 8'hA5 to 5'h03)
    rst_ = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'h03; cpu_wdata = 8'hA5;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 5'h03; ldr_wdata = 8'hA5;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_gnt", {cpu_gnt, ldr_gnt}, 0);
      chk("rst_strobes", {mem_rd, mem_wr, busy}, 0);
      chk("rst_rvalid", {cpu_rvalid, ldr_rvalid}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_rdata", {cpu_rdata, ldr_rdata}, 0);
    end
    rst_ = 1'b0;
    tick();
    chk("rel_cpu_gnt", cpu_gnt, !exp_ldr[0]);
    chk("rel_ldr_gnt", ldr_gnt, exp_ldr[0]);
    chk("rel_mem_wr", {mem_wr, mem_rd}, 2'b10);
    chk("rel_mem_addr", mem_addr, 5'h03);
    cpu_req = 1'b0; ldr_req = 1'b0;
    tick();
    chk("rel_idle", busy, 0);

    // CPU read of 5'h03
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h03;
    tick();
    chk("rd_cpu_gnt", {cpu_gnt, ldr_gnt}, 2'b10);
    chk("rd_mem_rd", {mem_rd, mem_wr}, 2'b10);
    chk("rd_mem_addr", mem_addr, 5'h03);
    chk("rd_busy", busy, 1);
    cpu_req = 1'b0;
    tick();
    chk("rd_rvalid", {cpu_rvalid, ldr_rvalid}, 2'b10);
    chk("rd_rdata", cpu_rdata, 8'hA5);
    chk("rd_strobes_off", {mem_rd, mem_wr, cpu_gnt}, 0);
    tick();
    chk("rd_done", {busy, cpu_rvalid}, 0);
    chk("rd_hold", cpu_rdata, 8'hA5);

    // Loader write 5'h1F <= 8'h3C, then CPU read it back
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 5'h1F; ldr_wdata = 8'h3C;
    tick();
    chk("lw_gnt", {cpu_gnt, ldr_gnt}, 2'b01);
    chk("lw_strobe", {mem_rd, mem_wr}, 2'b01);
    chk("lw_addr_data", {mem_addr, mem_wdata}, {5'h1F, 8'h3C});
    chk("lw_busy", busy, 1);
    ldr_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h1F;
    tick();
    chk("lw_end", {mem_wr, busy}, 0);
    tick();
    chk("rb_gnt", cpu_gnt, 1);
    cpu_req = 1'b0;
    tick();
    chk("rb_rvalid", {cpu_rvalid, ldr_rvalid}, 2'b10);
    chk("rb_rdata", cpu_rdata, 8'h3C);
    chk("rb_ldr_rdata", ldr_rdata, 8'h00);
    tick();

    // Both requests held: grant order and 3-cycle read spacing
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h03;
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 5'h1F;
    g = 0; last_cyc = 0; excl_bad = 1'b0;
    for (int cyc = 0; cyc < 40 && g < 4; cyc++) begin
      tick();
      if ((mem_rd && mem_wr) || (cpu_gnt && ldr_gnt)) excl_bad = 1'b1;
      if (cpu_gnt || ldr_gnt) begin
        chk($sformatf("arb_order%0d", g), ldr_gnt, exp_ldr[g]);
        if (g > 0) chk($sformatf("arb_spacing%0d", g), cyc - last_cyc, 3);
        last_cyc = cyc;
        g++;
      end
    end
    chk("arb_count", g, 4);
    chk("arb_exclusive", excl_bad, 0);
    cpu_req = 1'b0; ldr_req = 1'b0;
    tick(); tick();
    chk("arb_idle", busy, 0);

    // Reset pulsed in RD_WAIT of a loader read
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 5'h1F;
    tick();
    chk("ab_gnt", ldr_gnt, 1);
    ldr_req = 1'b0;
    tick();
    rst_ = 1'b1;
    #1;
    chk("ab_no_rvalid", ldr_rvalid, 0);
    tick();
    rst_ = 1'b0;
    chk("ab_idle", {busy, mem_rd, mem_wr, ldr_rvalid}, 0);
    chk("ab_rdata_cleared", ldr_rdata, 8'h00);
    ldr_req = 1'b1;
    tick();
    chk("ab_regnt", ldr_gnt, 1);
    ldr_req = 1'b0;
    tick();
    chk("ab_rvalid", ldr_rvalid, 1);
    chk("ab_rdata", ldr_rdata, 8'h3C);
    tick();

    // Back-to-back CPU writes with req held across each grant
    wa[0] = 8'h04; wa[1] = 8'h05; wa[2] = 8'h06;
    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = wa[0][4:0]; cpu_wdata = wd[0];
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("bb_gnt%0d", k), {cpu_gnt, mem_wr}, 2'b11);
      chk($sformatf("bb_addr_data%0d", k), {mem_addr, mem_wdata}, {wa[k][4:0], wd[k]});
      if (k < 2) begin
        cpu_addr = wa[k+1][4:0]; cpu_wdata = wd[k+1];
      end else begin
        cpu_req = 1'b0;
      end
      tick();
      chk($sformatf("bb_gap%0d", k), {cpu_gnt, mem_wr, busy}, 0);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h05;
    tick();
    cpu_req = 1'b0;
    tick();
    chk("bb_readback", {cpu_rvalid, cpu_rdata}, {1'b1, 8'h22});
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
